// File: rtl/soc_bus_fabric_if.sv
// Bus bundle for soc_bus_fabric: master-side request/response and
// slave-side select/handshake signals.
//   master : view of a bus master (drives requests, receives completions)
//   slave  : view of a decoded slave (receives selects, drives ready/rdata)
//   fabric : view of the interconnect itself
interface soc_bus_fabric_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]             m_req;
  logic [NUM_MASTERS-1:0]             m_we;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]             m_ack;
  logic                               m_err;
  logic [DATA_W-1:0]                  m_rdata;
  logic [NUM_SLAVES-1:0]              s_sel;
  logic                               s_we;
  logic [ADDR_W-1:0]                  s_addr;
  logic [DATA_W-1:0]                  s_wdata;
  logic [NUM_SLAVES-1:0]              s_ready;
  logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_rdata;

  modport master (output m_req, m_we, m_addr, m_wdata,
                  input  m_ack, m_err, m_rdata);
  modport slave  (input  s_sel, s_we, s_addr, s_wdata,
                  output s_ready, s_rdata);
  modport fabric (input  m_req, m_we, m_addr, m_wdata, s_ready, s_rdata,
                  output m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata);
endinterface

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: round-robin shared-bus interconnect, one transaction in
// flight. Base/mask decode (lowest slave index wins on overlap), decode
// misses answered with m_err. All outputs registered.
// Optional: define SOC_BUS_TIMEOUT_EN to abort a slave access with m_err
// after TIMEOUT_CYC cycles without s_ready.
module soc_bus_fabric #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  soc_bus_fabric_if.fabric bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 1 || NUM_SLAVES < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("soc_bus_fabric: NUM_MASTERS, NUM_SLAVES and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [MW-1:0]          rr_q, rr_d, owner_q, owner_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

`ifdef SOC_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]        to_q, to_d;
`endif

  logic                   gnt_vld;
  logic [MW-1:0]          gnt_idx, cand;
  logic [ADDR_W-1:0]      req_addr;
  logic                   hit_vld;
  logic [NUM_SLAVES-1:0]  hit_oh;
  logic [DATA_W-1:0]      rd_mux;
  logic                   ready_hit;

  // Round robin: scan downward so the requester nearest rr_q is kept last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = MW'((int'(rr_q) + i) % NUM_MASTERS);
      if (bus.m_req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign req_addr = bus.m_addr[gnt_idx];

  // Address decode of the granted request; lowest hitting slave overrides.
  always_comb begin
    hit_vld = 1'b0;
    hit_oh  = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if ((req_addr & SLV_MASK[s*ADDR_W +: ADDR_W]) == SLV_BASE[s*ADDR_W +: ADDR_W]) begin
        hit_vld = 1'b1;
        hit_oh  = NUM_SLAVES'(1) << s;
      end
    end
  end

  // Only the selected slave's ready/rdata are looked at.
  always_comb begin
    rd_mux = '0;
    for (int s = 0; s < NUM_SLAVES; s++)
      if (sel_q[s]) rd_mux = rd_mux | bus.s_rdata[s];
  end

  assign ready_hit = |(bus.s_ready & sel_q);

  // Next-state and next-output logic; m_ack is raised on entry to RESP.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef SOC_BUS_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          rr_d    = (gnt_idx == MW'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
          we_d    = bus.m_we[gnt_idx];
          addr_d  = req_addr;
          wdata_d = bus.m_wdata[gnt_idx];
          if (hit_vld) begin
            sel_d   = hit_oh;
            state_d = ACCESS;
`ifdef SOC_BUS_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            ack_d[gnt_idx] = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (ready_hit) begin
          sel_d          = '0;
          ack_d[owner_q] = 1'b1;
          err_d          = 1'b0;
          rdata_d        = we_q ? '0 : rd_mux;
          state_d        = RESP;
        end
`ifdef SOC_BUS_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          sel_d          = '0;
          ack_d[owner_q] = 1'b1;
          err_d          = 1'b1;
          rdata_d        = '0;
          state_d        = RESP;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef SOC_BUS_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef SOC_BUS_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign bus.m_ack   = ack_q;
  assign bus.m_err   = err_q;
  assign bus.m_rdata = rdata_q;
  assign bus.s_sel   = sel_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: expected completions are queued when a
// request is driven and popped by a monitor when m_ack appears.
module tb_soc_bus_fabric;
  localparam int NM = 2, NS = 4, AW = 32, DW = 32, TO = 8;
  // slave1 overlaps slave3 (0x30xx_xxxx) to exercise lowest-index priority
  localparam logic [NS*AW-1:0] BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h3000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;

  soc_bus_fabric_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  soc_bus_fabric #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NM-1:0] ack;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   slv_wait [NS];
  int   slv_cnt  [NS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [NM-1:0] a, input logic e, input logic [DW-1:0] d);
    exp_q.push_back('{a, e, d});
  endtask

  // Slave model: s_ready after slv_wait[i] selected cycles.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus.s_sel[i]) begin
        bus.s_ready[i] <= (slv_cnt[i] >= slv_wait[i]);
        slv_cnt[i]     <= slv_cnt[i] + 1;
      end else begin
        bus.s_ready[i] <= 1'b0;
        slv_cnt[i]     <= 0;
      end
    end
  end

  // Monitor: select is one-hot-or-zero; every m_ack matches the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (!$onehot0(bus.s_sel)) chk("sel_onehot", 64'(bus.s_sel), 64'(1));
      if (bus.m_ack !== '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(bus.m_ack), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ack_owner", 64'(bus.m_ack), 64'(e.ack));
          chk("ack_err", 64'(bus.m_err), 64'(e.err));
          chk("ack_rdata", 64'(bus.m_rdata), 64'(e.rdata));
          chk("ack_sel_clear", 64'(bus.s_sel), 64'(0));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 64'(bus.m_ack), 64'(0));
    chk({tag, "_err"}, 64'(bus.m_err), 64'(0));
    chk({tag, "_rdata"}, 64'(bus.m_rdata), 64'(0));
    chk({tag, "_sel"}, 64'(bus.s_sel), 64'(0));
    chk({tag, "_we"}, 64'(bus.s_we), 64'(0));
    chk({tag, "_addr"}, 64'(bus.s_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(bus.s_wdata), 64'(0));
  endtask

  task automatic req(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_req[m]   = 1'b1;
    bus.m_we[m]    = we;
    bus.m_addr[m]  = a;
    bus.m_wdata[m] = d;
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.m_ack !== '0) seen = 1'b1;
    end
    chk({tag, "_ack_seen"}, 64'(seen), 64'(1));
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n_sel, n_ack;
    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_rdata[0] = 32'hDEAD_BEEF;
    bus.s_rdata[1] = 32'h1111_0001;
    bus.s_rdata[2] = 32'h2222_0002;
    bus.s_rdata[3] = 32'h3333_0003;
    for (int i = 0; i < NS; i++) slv_wait[i] = 0;

    // reset values
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // M0 read from slave0, ready after 2 wait cycles
    slv_wait[0] = 2;
    req(0, 1'b0, 32'h0000_0010, '0);
    push(2'b01, 1'b0, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_sel", 64'(bus.s_sel), 64'(4'b0001));
    end
    chk("t1_addr", 64'(bus.s_addr), 64'(32'h0000_0010));
    @(negedge clk);
    chk("t1_ack_time", 64'(bus.m_ack), 64'(2'b01));
    bus.m_req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 64'(bus.m_ack), 64'(0));
    chk("t1_rdata_hold", 64'(bus.m_rdata), 64'(32'hDEAD_BEEF));

    // round robin from reset: both request continuously -> M0, M1, M0
    pulse_rst();
    slv_wait[0] = 0;
    slv_wait[2] = 0;
    req(0, 1'b0, 32'h0000_0010, '0);
    req(1, 1'b0, 32'h2000_0000, '0);
    push(2'b01, 1'b0, 32'hDEAD_BEEF);
    push(2'b10, 1'b0, 32'h2222_0002);
    push(2'b01, 1'b0, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) wait_ack("rr", 20);
    bus.m_req = '0;
    @(negedge clk);

    // M1 write to LED slave, zero-wait: ack two cycles after request
    req(1, 1'b1, 32'h2000_0004, 32'h0000_0005);
    push(2'b10, 1'b0, '0);
    @(negedge clk);
    chk("wr_sel", 64'(bus.s_sel), 64'(4'b0100));
    chk("wr_we", 64'(bus.s_we), 64'(1));
    chk("wr_wdata", 64'(bus.s_wdata), 64'(5));
    chk("wr_addr", 64'(bus.s_addr), 64'(32'h2000_0004));
    @(negedge clk);
    chk("wr_ack_time", 64'(bus.m_ack), 64'(2'b10));
    bus.m_req = '0;
    @(negedge clk);

    // overlapping decode: slave1 beats slave3; then slave3 alone
    slv_wait[1] = 1;
    slv_wait[3] = 1;
    req(0, 1'b0, 32'h3000_0010, '0);
    push(2'b01, 1'b0, 32'h1111_0001);
    @(negedge clk);
    chk("ovl_sel", 64'(bus.s_sel), 64'(4'b0010));
    wait_ack("ovl", 10);
    bus.m_req = '0;
    @(negedge clk);
    req(1, 1'b0, 32'h3100_0000, '0);
    push(2'b10, 1'b0, 32'h3333_0003);
    @(negedge clk);
    chk("s3_sel", 64'(bus.s_sel), 64'(4'b1000));
    wait_ack("s3", 10);
    bus.m_req = '0;
    @(negedge clk);

    // read miss and write miss: no select, err=1, rdata=0
    req(0, 1'b0, 32'hF000_0000, '0);
    push(2'b01, 1'b1, '0);
    @(negedge clk);
    chk("miss_sel", 64'(bus.s_sel), 64'(0));
    chk("miss_ack_time", 64'(bus.m_ack), 64'(2'b01));
    bus.m_req = '0;
    @(negedge clk);
    req(0, 1'b1, 32'h5000_0000, 32'h0000_00AA);
    push(2'b01, 1'b1, '0);
    @(negedge clk);
    chk("wmiss_sel", 64'(bus.s_sel), 64'(0));
    chk("wmiss_ack_time", 64'(bus.m_ack), 64'(2'b01));
    bus.m_req = '0;
    @(negedge clk);

    // master drops m_req mid-transaction: still acknowledged
    slv_wait[0] = 3;
    req(0, 1'b0, 32'h0000_0020, '0);
    push(2'b01, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.m_req = '0;
    wait_ack("drop", 20);
    @(negedge clk);

    // reset during ACCESS: outputs clear at once, no ack, then new request served
    slv_wait[3] = 1000000;
    req(0, 1'b0, 32'h3100_0000, '0);
    repeat (2) @(negedge clk);
    chk("rst_mid_sel", 64'(bus.s_sel), 64'(4'b1000));
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    bus.m_req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    slv_wait[0] = 0;
    req(1, 1'b0, 32'h0000_0010, '0);
    push(2'b10, 1'b0, 32'hDEAD_BEEF);
    wait_ack("post_rst", 10);
    bus.m_req = '0;
    @(negedge clk);

    // slave that never answers
    req(0, 1'b0, 32'h3100_0000, '0);
`ifdef SOC_BUS_TIMEOUT_EN
    push(2'b01, 1'b1, '0);
    n_sel = 0;
    n_ack = 0;
    for (int k = 0; k < 50 && n_ack == 0; k++) begin
      @(negedge clk);
      if (bus.s_sel[3]) n_sel++;
      if (bus.m_ack !== '0) n_ack++;
    end
    chk("to_access_cycles", 64'(n_sel), 64'(TO));
    chk("to_ack_seen", 64'(n_ack), 64'(1));
    bus.m_req = '0;
    @(negedge clk);
`else
    n_sel = 0;
    n_ack = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.s_sel[3]) n_sel++;
      if (bus.m_ack !== '0) n_ack++;
    end
    chk("noto_acks", 64'(n_ack), 64'(0));
    chk("noto_sel_held", 64'(n_sel), 64'(1000));
    bus.m_req = '0;
    pulse_rst();
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
